stimulus_sequencer: RTL and testbench
=====================================

STIMULUS_SEQUENCER -- requirements
Module: stimulus_sequencer

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- STIM_CYCLES, 16, stimulus-on duration in cycles.
- RESP_WINDOW, 64, maximum response-wait cycles after stimulus.
- GAP_CYCLES, 8, inter-trial pause in cycles.
- TRIALS, 4, trials per position.
- START_BRIGHT, 8'h80, initial brightness per position.
- STEP_INIT, 8'h40, initial staircase step.
- SPEED, 8'h10, speed value driven while busy.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, run request pulse.
- abort, in, 1, cancel run.
- response, in, 1, patient button, already synchronous to clk.
- pattern_valid, in, 1, pattern generator ready.
- brightness, out, 8, to pattern generator.
- speed, out, 8, to pattern generator.
- stim_index, out, 3, current position 0-7.
- stim_on, out, 1, stimulus displayed.
- busy, out, 1, run in progress.
- done, out, 1, one-cycle run-complete pulse.
- result_valid, out, 1, one-cycle result strobe.
- result_index, out, 3, position of the result.
- result_threshold, out, 8, threshold of the result.

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, WAIT_VALID, STIM, RESP, GAP, REPORT, DONE.
REQ-004 In IDLE, start=1 SHALL move to WAIT_VALID next cycle with busy=1, stim_index=0, brightness=START_BRIGHT, step=STEP_INIT, trial count=0.
REQ-005 start SHALL be ignored in any state other than IDLE.
REQ-006 WAIT_VALID SHALL hold until pattern_valid=1, then enter STIM next cycle.
REQ-007 STIM SHALL assert stim_on for exactly STIM_CYCLES consecutive cycles, then enter RESP; stim_on SHALL be 0 in all other states.
REQ-008 A seen flag SHALL be cleared on entering STIM and set by response=1 in any STIM or RESP cycle; it SHALL be set at most once per trial.
REQ-009 RESP SHALL exit to GAP on the cycle after seen is set, or after RESP_WINDOW cycles without response.
REQ-010 On entering GAP, brightness and step SHALL update as follows:
- seen: brightness = max(brightness - step, 0).
- not seen: brightness = min(brightness + step, 255), using 9-bit intermediate arithmetic.
- then: step = max(step >> 1, 1); trial count increments.
REQ-011 GAP SHALL last GAP_CYCLES cycles, then go to WAIT_VALID if trial count < TRIALS, else to REPORT.
REQ-012 REPORT SHALL last one cycle with result_valid=1, result_index=stim_index, result_threshold=brightness.
REQ-013 After REPORT:
- stim_index < 7: increment stim_index, reload START_BRIGHT/STEP_INIT, clear trial count, go to WAIT_VALID.
- stim_index = 7: go to DONE.
REQ-014 DONE SHALL last one cycle with done=1, then return to IDLE with busy=0.
REQ-015 speed SHALL equal SPEED while busy=1 and 8'h00 otherwise.
REQ-016 abort=1 in any non-IDLE state SHALL force IDLE next cycle with busy=0, stim_on=0, and no result_valid or done; abort has priority over every other transition.
REQ-017 response while pattern_valid=0, or in WAIT_VALID, GAP, REPORT, DONE or IDLE, SHALL have no effect.

Reset
REQ-018 rst_n=0 SHALL immediately force IDLE with all outputs 0, internal counters 0, and brightness=8'h00, independent of clk.
REQ-019 Reset released mid-run SHALL leave the block in IDLE; it SHALL require a new start.

Verification
REQ-020 The bench SHALL cover these directed scenarios (default parameters, pattern_valid=1):
- Response every trial -> per-trial brightness 0x40, 0x20, 0x10, 0x08; result_threshold=0x08 for all 8 positions; result_index 0..7; done pulses once.
- No response -> brightness 0xC0, 0xE0, 0xF0, 0xF8; each trial STIM_CYCLES+RESP_WINDOW+GAP_CYCLES+1 cycles; threshold 0xF8.
- Alternating seen/not/seen/not -> 0x40, 0x60, 0x50, 0x58; threshold 0x58.
- START_BRIGHT=8'hF0, no response -> brightness saturates at 0xFF; threshold 0xFF.
- pattern_valid held 0 for 20 cycles in WAIT_VALID -> stim_on stays 0 and response ignored; the trial proceeds once pattern_valid=1.
- abort during STIM of position 3 -> IDLE next cycle, busy=0, no result for 3; start mid-run ignored; rst_n low mid-RESP -> all outputs 0 immediately.

Source files
------------

// File: rtl/stimulus_sequencer.sv
// stimulus_sequencer
// Runs a staircase threshold search over eight stimulus positions. Each
// position gets TRIALS trials: wait for the pattern generator, show the
// stimulus, wait for the patient's button, then pause. Brightness steps
// down after a response and up after a miss, and the step halves every
// trial. After the last trial of a position the final brightness is
// reported as that position's threshold.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               run request pulse (only honoured in IDLE)
//   abort               cancel the run, back to IDLE next cycle
//   response            patient button, synchronous to clk
//   pattern_valid       pattern generator ready
//   brightness, speed   drive to the pattern generator
//   stim_index          current position 0-7
//   stim_on             stimulus displayed
//   busy                run in progress
//   done                one-cycle run-complete pulse
//   result_valid        one-cycle result strobe
//   result_index        position of the result
//   result_threshold    threshold of the result
//
// state      | meaning
// IDLE       | no run, waiting for start
// WAIT_VALID | holding until the pattern generator is ready
// STIM       | stimulus on for STIM_CYCLES cycles
// RESP       | waiting for a response, up to RESP_WINDOW cycles
// GAP        | inter-trial pause for GAP_CYCLES cycles
// REPORT     | one-cycle threshold report for the current position
// DONE       | one-cycle run-complete pulse
module stimulus_sequencer #(
    parameter int         STIM_CYCLES  = 16,
    parameter int         RESP_WINDOW  = 64,
    parameter int         GAP_CYCLES   = 8,
    parameter int         TRIALS       = 4,
    parameter logic [7:0] START_BRIGHT = 8'h80,
    parameter logic [7:0] STEP_INIT    = 8'h40,
    parameter logic [7:0] SPEED        = 8'h10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       response,
    input  logic       pattern_valid,
    output logic [7:0] brightness,
    output logic [7:0] speed,
    output logic [2:0] stim_index,
    output logic       stim_on,
    output logic       busy,
    output logic       done,
    output logic       result_valid,
    output logic [2:0] result_index,
    output logic [7:0] result_threshold
);

    typedef enum logic [2:0] {
        IDLE, WAIT_VALID, STIM, RESP, GAP, REPORT, DONE
    } state_t;

    localparam int              TW        = 16;
    localparam logic [TW-1:0]   STIM_LOAD = TW'(STIM_CYCLES - 1);
    localparam logic [TW-1:0]   RESP_LOAD = TW'(RESP_WINDOW - 1);
    localparam logic [TW-1:0]   GAP_LOAD  = TW'(GAP_CYCLES - 1);
    localparam logic [7:0]      TRIALS_L  = 8'(TRIALS);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    bright_q, bright_d;
    logic [7:0]    step_q, step_d;
    logic [7:0]    trial_q, trial_d;
    logic [2:0]    index_q, index_d;
    logic          seen_q, seen_d;

    logic          seen_set, seen_eff;
    logic [8:0]    sum9;
    logic [7:0]    bright_up, bright_dn, step_half;

    // A response only counts while the stimulus is showing or the window is
    // open, and only if the pattern generator is actually presenting.
    assign seen_set  = response && pattern_valid && (state_q == STIM || state_q == RESP);
    // A response in the very last RESP cycle still counts for this trial.
    assign seen_eff  = seen_q || seen_set;

    assign sum9      = {1'b0, bright_q} + {1'b0, step_q};
    assign bright_up = sum9[8] ? 8'hFF : sum9[7:0];
    assign bright_dn = (bright_q > step_q) ? (bright_q - step_q) : 8'h00;
    assign step_half = (step_q > 8'd1) ? {1'b0, step_q[7:1]} : 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            bright_q <= 8'h00;
            step_q   <= 8'h00;
            trial_q  <= 8'h00;
            index_q  <= 3'd0;
            seen_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bright_q <= bright_d;
            step_q   <= step_d;
            trial_q  <= trial_d;
            index_q  <= index_d;
            seen_q   <= seen_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        bright_d = bright_q;
        step_d   = step_q;
        trial_d  = trial_q;
        index_d  = index_q;
        seen_d   = seen_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = WAIT_VALID;
                    index_d  = 3'd0;
                    bright_d = START_BRIGHT;
                    step_d   = STEP_INIT;
                    trial_d  = 8'h00;
                end
            end
            WAIT_VALID: begin
                if (pattern_valid) begin
                    state_d = STIM;
                    timer_d = STIM_LOAD;
                    seen_d  = 1'b0;
                end
            end
            STIM: begin
                if (seen_set) seen_d = 1'b1;
                if (timer_q == '0) begin
                    state_d = RESP;
                    timer_d = RESP_LOAD;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            RESP: begin
                if (seen_set) seen_d = 1'b1;
                if (seen_q || timer_q == '0) begin
                    state_d  = GAP;
                    timer_d  = GAP_LOAD;
                    bright_d = seen_eff ? bright_dn : bright_up;
                    step_d   = step_half;
                    trial_d  = trial_q + 8'd1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            GAP: begin
                if (timer_q == '0) begin
                    state_d = (trial_q < TRIALS_L) ? WAIT_VALID : REPORT;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            REPORT: begin
                if (index_q != 3'd7) begin
                    state_d  = WAIT_VALID;
                    index_d  = index_q + 3'd1;
                    bright_d = START_BRIGHT;
                    step_d   = STEP_INIT;
                    trial_d  = 8'h00;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
        end
    end

    // Strobes are suppressed in an abort cycle so a cancelled run never
    // reports a result or completion.
    assign brightness       = bright_q;
    assign stim_index       = index_q;
    assign stim_on          = (state_q == STIM);
    assign busy             = (state_q != IDLE);
    assign speed            = busy ? SPEED : 8'h00;
    assign result_valid     = (state_q == REPORT) && !abort;
    assign done             = (state_q == DONE) && !abort;
    assign result_index     = (state_q == REPORT) ? index_q : 3'd0;
    assign result_threshold = (state_q == REPORT) ? bright_q : 8'h00;

endmodule

// File: tb/tb_stimulus_sequencer.sv
module tb_stimulus_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       response = 1'b0;
    logic       pattern_valid = 1'b0;

    logic [7:0] brightness, speed, result_threshold;
    logic [2:0] stim_index, result_index;
    logic       stim_on, busy, done, result_valid;

    logic [7:0] f_brightness, f_speed, f_result_threshold;
    logic [2:0] f_stim_index, f_result_index;
    logic       f_stim_on, f_busy, f_done, f_result_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stimulus_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .response         (response),
        .pattern_valid    (pattern_valid),
        .brightness       (brightness),
        .speed            (speed),
        .stim_index       (stim_index),
        .stim_on          (stim_on),
        .busy             (busy),
        .done             (done),
        .result_valid     (result_valid),
        .result_index     (result_index),
        .result_threshold (result_threshold)
    );

    // Same stimulus, high starting brightness to exercise the upper clamp.
    stimulus_sequencer #(.START_BRIGHT(8'hF0)) dut_f0 (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .response         (response),
        .pattern_valid    (pattern_valid),
        .brightness       (f_brightness),
        .speed            (f_speed),
        .stim_index       (f_stim_index),
        .stim_on          (f_stim_on),
        .busy             (f_busy),
        .done             (f_done),
        .result_valid     (f_result_valid),
        .result_index     (f_result_index),
        .result_threshold (f_result_threshold)
    );

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if ({brightness, speed, stim_index, stim_on, busy, done, result_valid,
             result_index, result_threshold} !== 37'd0) begin
            bad++;
            $display("FAIL reset_outputs: got b=%h s=%h idx=%0d on=%b busy=%b done=%b rv=%b ri=%0d rt=%h want all zero",
                     brightness, speed, stim_index, stim_on, busy, done, result_valid,
                     result_index, result_threshold);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || speed !== 8'h00) begin
            bad++;
            $display("FAIL reset_release_idle: busy=%b speed=%h want 0/00", busy, speed);
        end
    endtask

    // exp_b holds the brightness after trials 1..4 in bytes 0..3.
    task automatic run_sweep(input string name, input logic [3:0] seen_pat,
                             input logic [31:0] exp_b, input logic [7:0] exp_thr,
                             input int exp_period, input bit chk_f0);
        int         trial_n;
        int         pos;
        int         last_rise;
        int         n_done;
        bit         finished;
        logic       prev_on;
        logic [7:0] exp_pre;
        logic [7:0] exp_f0;
        trial_n = 0; pos = 0; last_rise = 0; n_done = 0; finished = 0; prev_on = 1'b0;
        pattern_valid = 1'b1;
        response = 1'b0;
        pulse_start();
        total++;
        if (busy !== 1'b1 || speed !== 8'h10) begin
            bad++;
            $display("FAIL %s busy_after_start: busy=%b speed=%h want 1/10", name, busy, speed);
        end
        for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
            @(negedge clk);
            if (stim_on && !prev_on) begin
                exp_pre = (trial_n == 0) ? 8'h80 : exp_b[8*(trial_n-1) +: 8];
                total++;
                if (trial_n > 3 || brightness !== exp_pre) begin
                    bad++;
                    $display("FAIL %s trial_brightness pos=%0d trial=%0d: got %h want %h",
                             name, pos, trial_n, brightness, exp_pre);
                end
                if (chk_f0) begin
                    exp_f0 = (trial_n == 0) ? 8'hF0 : 8'hFF;
                    total++;
                    if (f_brightness !== exp_f0) begin
                        bad++;
                        $display("FAIL %s f0_brightness pos=%0d trial=%0d: got %h want %h",
                                 name, pos, trial_n, f_brightness, exp_f0);
                    end
                end
                if (exp_period != 0 && trial_n > 0) begin
                    total++;
                    if (cyc - last_rise != exp_period) begin
                        bad++;
                        $display("FAIL %s trial_period pos=%0d trial=%0d: got %0d want %0d",
                                 name, pos, trial_n, cyc - last_rise, exp_period);
                    end
                end
                last_rise = cyc;
                response = (trial_n < 4) ? seen_pat[trial_n] : 1'b0;
                trial_n++;
            end
            prev_on = stim_on;
            if (result_valid) begin
                total++;
                if (result_index !== pos[2:0] || result_threshold !== exp_thr || trial_n != 4) begin
                    bad++;
                    $display("FAIL %s result pos=%0d: got idx=%0d thr=%h trials=%0d want idx=%0d thr=%h trials=4",
                             name, pos, result_index, result_threshold, trial_n, pos, exp_thr);
                end
                if (chk_f0) begin
                    total++;
                    if (f_result_valid !== 1'b1 || f_result_threshold !== 8'hFF) begin
                        bad++;
                        $display("FAIL %s f0_result pos=%0d: got rv=%b thr=%h want 1/FF",
                                 name, pos, f_result_valid, f_result_threshold);
                    end
                end
                pos++;
                trial_n = 0;
            end
            if (done) begin
                n_done++;
                finished = 1;
            end
        end
        total++;
        if (!finished) begin
            bad++;
            $display("FAIL %s timeout: done not seen within 6000 cycles", name);
        end
        total++;
        if (pos != 8) begin
            bad++;
            $display("FAIL %s result_count: got %0d want 8", name, pos);
        end
        repeat (3) begin
            @(negedge clk);
            if (done) n_done++;
        end
        total++;
        if (busy !== 1'b0 || speed !== 8'h00 || n_done != 1) begin
            bad++;
            $display("FAIL %s end_state: busy=%b speed=%h done_pulses=%0d want 0/00/1",
                     name, busy, speed, n_done);
        end
        response = 1'b0;
    endtask

    task automatic test_all_seen();
        run_sweep("all_seen", 4'b1111, {8'h08, 8'h10, 8'h20, 8'h40}, 8'h08, 0, 1'b0);
    endtask

    task automatic test_no_response();
        run_sweep("no_resp", 4'b0000, {8'hF8, 8'hF0, 8'hE0, 8'hC0}, 8'hF8, 16 + 64 + 8 + 1, 1'b1);
    endtask

    task automatic test_alternating();
        run_sweep("alternating", 4'b0101, {8'h58, 8'h50, 8'h60, 8'h40}, 8'h58, 0, 1'b0);
    endtask

    task automatic test_pattern_valid();
        int errs;
        errs = 0;
        pattern_valid = 1'b0;
        response = 1'b1;
        pulse_start();
        repeat (20) begin
            @(negedge clk);
            if (stim_on !== 1'b0 || busy !== 1'b1) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL pv_hold: %0d cycles with stim_on!=0 or busy!=1, want 0", errs);
        end
        pattern_valid = 1'b1;
        @(negedge clk);
        total++;
        if (stim_on !== 1'b1 || brightness !== 8'h80) begin
            bad++;
            $display("FAIL pv_stim_entry: stim_on=%b b=%h want 1/80", stim_on, brightness);
        end
        // Button held but generator not presenting: trial must count as a miss.
        pattern_valid = 1'b0;
        repeat (90) @(negedge clk);
        total++;
        if (brightness !== 8'hC0 || stim_on !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL pv_response_ignored: b=%h on=%b busy=%b want C0/0/1",
                     brightness, stim_on, busy);
        end
        response = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL pv_abort_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_abort();
        bit found;
        int evts;
        found = 0;
        evts = 0;
        pattern_valid = 1'b1;
        response = 1'b1;
        pulse_start();
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (stim_on && stim_index == 3'd3) found = 1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL abort_reach_pos3: timeout, idx=%0d want 3", stim_index);
        end
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (stim_index !== 3'd3 || stim_on !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL start_ignored: idx=%0d on=%b busy=%b want 3/1/1", stim_index, stim_on, busy);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || stim_on !== 1'b0 || speed !== 8'h00 || result_valid !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: busy=%b on=%b speed=%h rv=%b done=%b want 0/0/00/0/0",
                     busy, stim_on, speed, result_valid, done);
        end
        repeat (60) begin
            @(negedge clk);
            if (result_valid || done || busy) evts++;
        end
        total++;
        if (evts != 0) begin
            bad++;
            $display("FAIL abort_stays_idle: %0d cycles with activity, want 0", evts);
        end
        response = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        bit found;
        found = 0;
        pattern_valid = 1'b1;
        response = 1'b0;
        pulse_start();
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (stim_on) found = 1;
        end
        repeat (16 + 5) @(negedge clk);
        total++;
        if (!found || stim_on !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL rst_reach_resp: found=%b on=%b busy=%b want 1/0/1", found, stim_on, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({brightness, speed, stim_index, stim_on, busy, done, result_valid,
             result_index, result_threshold} !== 37'd0) begin
            bad++;
            $display("FAIL rst_mid_run_outputs: b=%h s=%h idx=%0d on=%b busy=%b want all zero",
                     brightness, speed, stim_index, stim_on, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (busy !== 1'b0 || stim_on !== 1'b0) begin
            bad++;
            $display("FAIL rst_needs_start: busy=%b on=%b want 0/0", busy, stim_on);
        end
        pulse_start();
        total++;
        if (busy !== 1'b1 || brightness !== 8'h80) begin
            bad++;
            $display("FAIL rst_restart: busy=%b b=%h want 1/80", busy, brightness);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_all_seen();
        test_no_response();
        test_alternating();
        test_pattern_valid();
        test_abort();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
